// File: rtl/sha256_multiblock.sv
// Multi-block SHA-256 engine: reads a word-addressed message from memory, pads it on the fly,
// and writes the 8-word digest back. Define SHA256_DIGEST_PORT_EN to add a direct digest port.
module sha256_multiblock #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [15:0]       num_words,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
`ifdef SHA256_DIGEST_PORT_EN
  ,
  output logic [255:0]      digest,
  output logic              digest_valid
`endif
);

  localparam int PW = $clog2(MAX_WORDS + 20);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ROUND  = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
    return (x >> r) | (x << (32 - r));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  // Word p of the padded message; tot is the padded length (16 * block count).
  function automatic logic [31:0] pad_word(input logic [PW-1:0] p, input logic [PW-1:0] n,
                                           input logic [PW-1:0] tot, input logic [31:0] rd);
    logic [31:0] n32;
    n32 = 32'(n);
    if (p < n)                      return rd;
    else if (p == n)                return 32'h80000000;
    else if (p == tot - PW'(2))     return n32 >> 27;
    else if (p == tot - PW'(1))     return n32 << 5;
    else                            return 32'h00000000;
  endfunction

  logic [2:0]        state_r;
  logic [6:0]        cnt_r;
  logic [PW-1:0]     n_r, tot_r, base_p_r;
  logic [ADDR_W-1:0] msg_base_r, out_base_r;
  logic [31:0]       h_r [8];
  logic [31:0]       v_r [8];
  logic [31:0]       w_r [16];
  logic              done_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_write_data_r;

  logic [PW-1:0]     n_s, tot_s, p_cap_s, p_nxt_s, blk_next_s;
  logic [31:0]       load_word_s, w_new_s, t1_s, t2_s;
  logic [31:0]       h_sum_s [8];

  // Padding/length arithmetic, message schedule extension and one compression round.
  always_comb begin
    if (num_words > 16'(MAX_WORDS)) begin
      n_s = PW'(MAX_WORDS);
    end else begin
      n_s = PW'(num_words);
    end
    tot_s       = (n_s + PW'(18)) & ~PW'(15);
    p_cap_s     = base_p_r + PW'(cnt_r) - PW'(1);
    p_nxt_s     = base_p_r + PW'(cnt_r) + PW'(1);
    blk_next_s  = base_p_r + PW'(16);
    load_word_s = pad_word(p_cap_s, n_r, tot_r, mem_read_data);
    w_new_s     = ssig1(w_r[14]) + w_r[9] + ssig0(w_r[1]) + w_r[0];
    t1_s = v_r[7] + bsig1(v_r[4]) + ((v_r[4] & v_r[5]) ^ (~v_r[4] & v_r[6]))
         + K_TAB[cnt_r[5:0]] + w_r[0];
    t2_s = bsig0(v_r[0]) + ((v_r[0] & v_r[1]) ^ (v_r[0] & v_r[2]) ^ (v_r[1] & v_r[2]));
    for (int i = 0; i < 8; i++) begin
      h_sum_s[i] = h_r[i] + v_r[i];
    end
  end

`ifdef SHA256_DIGEST_PORT_EN
  logic digest_valid_r;
`endif

  // Main FSM with datapath registers and registered memory-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 7'd0;
      n_r              <= '0;
      tot_r            <= '0;
      base_p_r         <= '0;
      msg_base_r       <= '0;
      out_base_r       <= '0;
      done_r           <= 1'b1;
      mem_we_r         <= 1'b0;
      mem_addr_r       <= '0;
      mem_write_data_r <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        h_r[i] <= 32'd0;
        v_r[i] <= 32'd0;
      end
      for (int i = 0; i < 16; i++) begin
        w_r[i] <= 32'd0;
      end
`ifdef SHA256_DIGEST_PORT_EN
      digest_valid_r   <= 1'b0;
`endif
    end else begin
`ifdef SHA256_DIGEST_PORT_EN
      digest_valid_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_LOAD;
            cnt_r      <= 7'd0;
            done_r     <= 1'b0;
            n_r        <= n_s;
            tot_r      <= tot_s;
            base_p_r   <= '0;
            msg_base_r <= message_addr;
            out_base_r <= output_addr;
            for (int i = 0; i < 8; i++) begin
              h_r[i] <= IV[i];
              v_r[i] <= IV[i];
            end
            if (n_s != '0) begin
              mem_addr_r <= message_addr;
            end
          end
        end
        ST_LOAD: begin
          // Slot 0 only issues an address; slots 1..16 each capture one padded word.
          if (cnt_r != 7'd0) begin
            for (int i = 0; i < 15; i++) begin
              w_r[i] <= w_r[i+1];
            end
            w_r[15] <= load_word_s;
          end
          if (cnt_r < 7'd15 && p_nxt_s < n_r) begin
            mem_addr_r <= msg_base_r + ADDR_W'(p_nxt_s);
          end
          if (cnt_r == 7'd16) begin
            state_r <= ST_ROUND;
            cnt_r   <= 7'd0;
          end else begin
            cnt_r <= cnt_r + 7'd1;
          end
        end
        ST_ROUND: begin
          v_r[0] <= t1_s + t2_s;
          v_r[1] <= v_r[0];
          v_r[2] <= v_r[1];
          v_r[3] <= v_r[2];
          v_r[4] <= v_r[3] + t1_s;
          v_r[5] <= v_r[4];
          v_r[6] <= v_r[5];
          v_r[7] <= v_r[6];
          for (int i = 0; i < 15; i++) begin
            w_r[i] <= w_r[i+1];
          end
          w_r[15] <= w_new_s;
          if (cnt_r == 7'd63) begin
            state_r <= ST_UPDATE;
            cnt_r   <= 7'd0;
          end else begin
            cnt_r <= cnt_r + 7'd1;
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) begin
            h_r[i] <= h_sum_s[i];
            v_r[i] <= h_sum_s[i];
          end
          base_p_r <= blk_next_s;
          cnt_r    <= 7'd0;
          if (blk_next_s < tot_r) begin
            state_r <= ST_LOAD;
            if (blk_next_s < n_r) begin
              mem_addr_r <= msg_base_r + ADDR_W'(blk_next_s);
            end
          end else begin
            state_r          <= ST_WRITE;
            mem_we_r         <= 1'b1;
            mem_addr_r       <= out_base_r;
            mem_write_data_r <= h_sum_s[0];
`ifdef SHA256_DIGEST_PORT_EN
            digest_valid_r   <= 1'b1;
`endif
          end
        end
        ST_WRITE: begin
          if (cnt_r == 7'd7) begin
            state_r  <= ST_IDLE;
            done_r   <= 1'b1;
            mem_we_r <= 1'b0;
          end else begin
            mem_addr_r       <= out_base_r + ADDR_W'(cnt_r) + ADDR_W'(1);
            mem_write_data_r <= h_r[cnt_r[2:0] + 3'd1];
            cnt_r            <= cnt_r + 7'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          done_r   <= 1'b1;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign done           = done_r;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_write_data = mem_write_data_r;

`ifdef SHA256_DIGEST_PORT_EN
  assign digest       = {h_r[0], h_r[1], h_r[2], h_r[3], h_r[4], h_r[5], h_r[6], h_r[7]};
  assign digest_valid = digest_valid_r;
`endif

endmodule
